// File: rtl/i2s_audio.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_audio
//  Purpose  : Audio back-end. Mixes the beeper bits (speaker, mic, ear) and
//             two PSG channel sets into 16-bit stereo PCM. Presents the PCM
//             as parallel words with a one-clock strobe, and serialises it as
//             standard I2S (MSB first, one SCLK of delay after LRCLK edge).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SCLK_DIV  clocks per SCLK period (4, 8 or 16); frame = 64*SCLK_DIV clocks
//    DW        PCM word width, fixed at 16
//  Ports
//    clock            system clock (clock28)
//    reset            asynchronous, active-low reset
//    speaker/mic/ear  beeper bits
//    a1,b1,c1         PSG #1 channel levels, unsigned 8-bit
//    a2,b2,c2         PSG #2 channel levels, unsigned 8-bit
//    mix              1 = ACB stereo, 0 = ABC stereo
//    left/right       last latched samples, two's complement
//    strobe           one-clock pulse when left/right update
//    mclk/sclk/lrclk  I2S clocks (lrclk 0 = left slot)
//    sdin             I2S serial data
//  Build option
//    AUDIO_LPF_EN     when defined, each channel passes a one-pole low-pass
//                     y <= y + ((x - y) >>> 2), updated at the latch edge
// ============================================================================
module i2s_audio #(
   parameter int SCLK_DIV = 8,
   parameter int DW       = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          speaker,
   input  logic          mic,
   input  logic          ear,
   input  logic [7:0]    a1,
   input  logic [7:0]    b1,
   input  logic [7:0]    c1,
   input  logic [7:0]    a2,
   input  logic [7:0]    b2,
   input  logic [7:0]    c2,
   input  logic          mix,
   output logic [DW-1:0] left,
   output logic [DW-1:0] right,
   output logic          strobe,
   output logic          mclk,
   output logic          sclk,
   output logic          lrclk,
   output logic          sdin
);

   localparam int SW = $clog2(SCLK_DIV);   // low counter bits: phase within one SCLK
   localparam int CW = SW + 6;             // 64 SCLK periods per frame

   logic [CW-1:0] cnt;
   logic [DW-1:0] tx_l;
   logic [DW-1:0] tx_r;

   logic [4:0]    pos;        // bit position within the current slot
   logic          slot;       // 0 = left, 1 = right
   logic          last;       // final clock of the frame: latch edge
   logic          bit_edge;   // SCLK phase wraps to zero

   assign pos      = cnt[SW+4:SW];
   assign slot     = cnt[CW-1];
   assign last     = &cnt;
   assign bit_edge = (cnt[SW-1:0] == '0);

   // The I2S clocks are taken straight from counter flops, so they stay glitch-free.
   assign mclk  = cnt[0];
   assign sclk  = cnt[SW-1];
   assign lrclk = slot;

   // ---------------------------------------------------------------- mixer
   // ACB puts C in the centre; ABC puts B in the centre.
   logic [9:0]    l1, r1, l2, r2, beep;
   logic [11:0]   sum_l, sum_r;
   logic [DW-1:0] pcm_l, pcm_r, new_l, new_r;

   assign l1 = {1'b0, a1, 1'b0} + {2'b00, (mix ? c1 : b1)};
   assign r1 = {1'b0, (mix ? b1 : c1), 1'b0} + {2'b00, (mix ? c1 : b1)};
   assign l2 = {1'b0, a2, 1'b0} + {2'b00, (mix ? c2 : b2)};
   assign r2 = {1'b0, (mix ? b2 : c2), 1'b0} + {2'b00, (mix ? c2 : b2)};

   assign beep = (speaker ? 10'd384 : 10'd0) + (ear ? 10'd128 : 10'd0)
               + (mic ? 10'd64 : 10'd0);

   // Worst case 765 + 765 + 576 = 2106, so 12 bits never overflow.
   assign sum_l = {2'b00, l1} + {2'b00, l2} + {2'b00, beep};
   assign sum_r = {2'b00, r1} + {2'b00, r2} + {2'b00, beep};

   // Offset binary to two's complement: silence maps to 16'h8000.
   assign pcm_l = {sum_l, 4'b0000} ^ 16'h8000;
   assign pcm_r = {sum_r, 4'b0000} ^ 16'h8000;

`ifdef AUDIO_LPF_EN
   // left/right double as the filter state y. The result always lies between
   // y and x, so dropping the 17th bit loses nothing.
   logic signed [16:0] diff_l, diff_r, step_l, step_r;

   assign diff_l = $signed({pcm_l[DW-1], pcm_l}) - $signed({left[DW-1], left});
   assign diff_r = $signed({pcm_r[DW-1], pcm_r}) - $signed({right[DW-1], right});
   assign step_l = diff_l >>> 2;
   assign step_r = diff_r >>> 2;
   assign new_l  = 16'($signed({left[DW-1], left}) + step_l);
   assign new_r  = 16'($signed({right[DW-1], right}) + step_r);
`else
   assign new_l = pcm_l;
   assign new_r = pcm_r;
`endif

   // ------------------------------------------------- counter, latch, serialiser
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         left   <= '0;
         right  <= '0;
         strobe <= 1'b0;
         tx_l   <= '0;
         tx_r   <= '0;
         sdin   <= 1'b0;
      end else begin
         cnt    <= cnt + CW'(1);
         strobe <= last;

         if (last) begin
            left  <= new_l;
            right <= new_r;
            tx_l  <= new_l;
            tx_r  <= new_r;
         end

         // Positions 1..16 carry the word MSB first; the shift register
         // empties by the end of the slot, so the tail of the slot is zero.
         if (bit_edge) begin
            if (pos >= 5'd1 && pos <= 5'd16) begin
               if (slot) begin
                  sdin <= tx_r[DW-1];
                  tx_r <= {tx_r[DW-2:0], 1'b0};
               end else begin
                  sdin <= tx_l[DW-1];
                  tx_l <= {tx_l[DW-2:0], 1'b0};
               end
            end else begin
               sdin <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire
